// File: rtl/ddr_host_request.sv
// ----------------------------------------------------------------------------
// ddr_host_request
//
// Host-side request sequencer placed directly upstream of the DDR SDRAM
// controller. Host requests are buffered in a small FIFO and issued to the
// controller one at a time. Each command is held until CMDACK. Write data
// is held stable afterwards, and read data is captured after a fixed
// latency and returned with a one-cycle strobe.
//
// Single clock domain (CLK) with a synchronous, active-high RESET.
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous reset, active-high
//   REQ_VALID  in   host request valid
//   REQ_READY  out  FIFO not full (transfer on REQ_VALID & REQ_READY)
//   REQ_CMD    in   [2:0] command code (000 NOP is accepted and dropped)
//   REQ_ADDR   in   [ASIZE-1:0] request address
//   REQ_DATA   in   [DSIZE-1:0] write data
//   REQ_DM     in   [DSIZE/8-1:0] write byte mask
//   RD_VALID   out  one-cycle strobe, RD_DATA valid
//   RD_DATA    out  [DSIZE-1:0] read return data
//   BUSY       out  FIFO non-empty or sequencer not idle
//   ERR        out  sticky acknowledge-timeout flag
//   CMD        out  [2:0] command to controller
//   ADDR       out  [ASIZE-1:0] address to controller
//   DATAIN     out  [DSIZE-1:0] write data to controller
//   DM         out  [DSIZE/8-1:0] byte mask to controller
//   CMDACK     in   single-cycle acknowledge from controller
//   DATAOUT    in   [DSIZE-1:0] read data from controller
//
// Read timing: with the acknowledge in cycle A, DATAOUT is sampled at the
// end of cycle A+RD_LAT. RD_VALID/RD_DATA are presented in cycle A+RD_LAT+1.
//
// Optional feature macro: DDR_REQ_TIMEOUT_EN
//   Defined   : ISSUE is bounded to TIMEOUT cycles. On expiry the command is
//               dropped, ERR is set (sticky) and the sequencer moves on.
//   Undefined : ISSUE waits indefinitely for CMDACK and ERR stays 0.
//
// Parameter constraints: DEPTH is a power of 2 and >= 2.
// WR_HOLD >= 1, 1 <= RD_LAT <= 15, and TIMEOUT >= 1.
// ----------------------------------------------------------------------------
module ddr_host_request #(
  parameter int ASIZE   = 22,
  parameter int DSIZE   = 128,
  parameter int DEPTH   = 4,
  parameter int WR_HOLD = 2,
  parameter int RD_LAT  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [2:0]           REQ_CMD,
  input  logic [ASIZE-1:0]     REQ_ADDR,
  input  logic [DSIZE-1:0]     REQ_DATA,
  input  logic [DSIZE/8-1:0]   REQ_DM,
  output logic                 RD_VALID,
  output logic [DSIZE-1:0]     RD_DATA,
  output logic                 BUSY,
  output logic                 ERR,
  output logic [2:0]           CMD,
  output logic [ASIZE-1:0]     ADDR,
  output logic [DSIZE-1:0]     DATAIN,
  output logic [DSIZE/8-1:0]   DM,
  input  logic                 CMDACK,
  input  logic [DSIZE-1:0]     DATAOUT
);

  localparam int DMW     = DSIZE / 8;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SEQ_MAX = (WR_HOLD > RD_LAT) ? WR_HOLD : RD_LAT;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_READA  = 3'b001;
  localparam logic [2:0] CMD_WRITEA = 3'b010;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [SEQ_W-1:0] SEQ_ZERO  = {SEQ_W{1'b0}};
  localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] WR_LAST   = SEQ_W'(WR_HOLD - 1);
  localparam logic [SEQ_W-1:0] RD_LAST   = SEQ_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // FIFO storage
  logic [2:0]       fifo_cmd_r  [DEPTH];
  logic [ASIZE-1:0] fifo_addr_r [DEPTH];
  logic [DSIZE-1:0] fifo_data_r [DEPTH];
  logic [DMW-1:0]   fifo_dm_r   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             push_s;
  logic             pop_s;

  // Sequencer
  state_t           state_r;
  state_t           state_next_s;
  logic [SEQ_W-1:0] seq_cnt_r;
  logic [SEQ_W-1:0] seq_cnt_next_s;
  logic             cmd_clear_s;
  logic             capture_s;

  // Registered outputs
  logic [2:0]       cmd_r;
  logic [ASIZE-1:0] addr_r;
  logic [DSIZE-1:0] datain_r;
  logic [DMW-1:0]   dm_r;
  logic             rd_valid_r;
  logic [DSIZE-1:0] rd_data_r;
  logic             busy_r;
  logic             ready_r;
  logic             err_r;

`ifdef DDR_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_r;
  logic            to_expire_s;

  assign to_expire_s = (to_cnt_r == TO_LAST);
`endif

  // Host NOPs complete the handshake but are never stored.
  assign push_s = REQ_VALID & ready_r & (REQ_CMD != CMD_NOP);

  // FIFO occupancy after this edge
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_cmd_r[i]  <= CMD_NOP;
        fifo_addr_r[i] <= {ASIZE{1'b0}};
        fifo_data_r[i] <= {DSIZE{1'b0}};
        fifo_dm_r[i]   <= {DMW{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_cmd_r[wr_ptr_r]  <= REQ_CMD;
        fifo_addr_r[wr_ptr_r] <= REQ_ADDR;
        fifo_data_r[wr_ptr_r] <= REQ_DATA;
        fifo_dm_r[wr_ptr_r]   <= REQ_DM;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Sequencer next-state and control decode
  always_comb begin
    state_next_s   = state_r;
    seq_cnt_next_s = seq_cnt_r;
    pop_s          = 1'b0;
    cmd_clear_s    = 1'b0;
    capture_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO) begin
          pop_s        = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (CMDACK) begin
          cmd_clear_s    = 1'b1;
          seq_cnt_next_s = SEQ_ZERO;
          if (cmd_r == CMD_WRITEA) begin
            state_next_s = ST_WDATA;
          end else if (cmd_r == CMD_READA) begin
            state_next_s = ST_RDWAIT;
          end else begin
            state_next_s = ST_GAP;
          end
        end
`ifdef DDR_REQ_TIMEOUT_EN
        else if (to_expire_s) begin
          // Drop the command; a dropped READA never produces RD_VALID.
          cmd_clear_s  = 1'b1;
          state_next_s = ST_GAP;
        end
`endif
        else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WDATA: begin
        // DATAIN/DM are untouched here; this state only delays the GAP.
        if (seq_cnt_r == WR_LAST) begin
          state_next_s = ST_GAP;
        end else begin
          seq_cnt_next_s = seq_cnt_r + SEQ_ONE;
        end
      end
      ST_RDWAIT: begin
        // Last RDWAIT cycle is ack cycle + RD_LAT: DATAOUT is sampled now.
        if (seq_cnt_r == RD_LAST) begin
          capture_s    = 1'b1;
          state_next_s = ST_GAP;
        end else begin
          seq_cnt_next_s = seq_cnt_r + SEQ_ONE;
        end
      end
      ST_GAP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and latency counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      seq_cnt_r <= SEQ_ZERO;
    end else begin
      state_r   <= state_next_s;
      seq_cnt_r <= seq_cnt_next_s;
    end
  end

`ifdef DDR_REQ_TIMEOUT_EN
  // Acknowledge watchdog; restarts on every entry into ISSUE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      to_cnt_r <= TO_ZERO;
    end else if ((state_r == ST_ISSUE) && (state_next_s == ST_ISSUE)) begin
      to_cnt_r <= to_cnt_r + TO_ONE;
    end else begin
      to_cnt_r <= TO_ZERO;
    end
  end
`endif

  // Controller-facing command registers, read return and status flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_r      <= CMD_NOP;
      addr_r     <= {ASIZE{1'b0}};
      datain_r   <= {DSIZE{1'b0}};
      dm_r       <= {DMW{1'b0}};
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DSIZE{1'b0}};
      busy_r     <= 1'b0;
      ready_r    <= 1'b1;
      err_r      <= 1'b0;
    end else begin
      // ADDR/DATAIN/DM only change when a new command is loaded.
      if (pop_s) begin
        cmd_r    <= fifo_cmd_r[rd_ptr_r];
        addr_r   <= fifo_addr_r[rd_ptr_r];
        datain_r <= fifo_data_r[rd_ptr_r];
        dm_r     <= fifo_dm_r[rd_ptr_r];
      end else if (cmd_clear_s) begin
        cmd_r <= CMD_NOP;
      end
      rd_valid_r <= capture_s;
      if (capture_s) begin
        rd_data_r <= DATAOUT;
      end
      // Status flags are computed from next-state so they line up with the
      // registers they describe.
      busy_r  <= (count_next_s != CNT_ZERO) || (state_next_s != ST_IDLE);
      ready_r <= (count_next_s != CNT_DEPTH);
`ifdef DDR_REQ_TIMEOUT_EN
      err_r <= err_r | ((state_r == ST_ISSUE) & ~CMDACK & to_expire_s);
`else
      err_r <= 1'b0;
`endif
    end
  end

  assign CMD       = cmd_r;
  assign ADDR      = addr_r;
  assign DATAIN    = datain_r;
  assign DM        = dm_r;
  assign RD_VALID  = rd_valid_r;
  assign RD_DATA   = rd_data_r;
  assign BUSY      = busy_r;
  assign REQ_READY = ready_r;
  assign ERR       = err_r;

endmodule
